// File: rtl/dcpu_pkg.sv
// rtl/dcpu_pkg.sv - shared arbiter types and defaults
package dcpu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } arb_state_e;

   typedef logic port_id_t;

   localparam int MAXWAIT_DEF = 8;

endpackage

// File: rtl/arb_starve_ctr.sv
// rtl/arb_starve_ctr.sv - saturating consecutive-denial counter
module arb_starve_ctr #(
   parameter int MAXWAIT = 8,
   localparam int CW = $clog2(MAXWAIT + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic inc_i,
   output logic at_max_o
);

   logic [CW-1:0] cnt_q, cnt_d;

   assign at_max_o = (cnt_q == CW'(MAXWAIT));

   // clr with inc restarts the count at one: a new port has just been denied
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = inc_i ? CW'(1) : '0;
      else if (inc_i && !at_max_o)
         cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port memory arbiter with lock and starvation override
module mem_arbiter
   import dcpu_pkg::*;
#(
   parameter int AWIDTH  = 16,
   parameter int DWIDTH  = 16,
   parameter int MAXWAIT = MAXWAIT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic              lock0,
   input  logic              lock1,
   input  logic [AWIDTH-2:0] addr0,
   input  logic [AWIDTH-2:0] addr1,
   input  logic [DWIDTH-1:0] wdata0,
   input  logic [DWIDTH-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DWIDTH-1:0] rdata,
   output logic              mem_re,
   output logic              mem_we,
   output logic [AWIDTH-2:0] memaddr,
   output logic [DWIDTH-1:0] wmemdata,
   input  logic [DWIDTH-1:0] rmemdata
);

   arb_state_e state_q, state_d;
   port_id_t   last_q, last_d;
   logic       rd_valid_q, rd_valid_d;
   port_id_t   rd_port_q, rd_port_d;
   logic       at_max, override, denied, switched;

   arb_starve_ctr #(.MAXWAIT(MAXWAIT)) u_starve (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (!denied || switched),
      .inc_i    (denied && !override),
      .at_max_o (at_max)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         last_q     <= 1'b1;
         rd_valid_q <= 1'b0;
         rd_port_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         rd_valid_q <= rd_valid_d;
         rd_port_q  <= rd_port_d;
      end
   end

   always_comb begin
      state_d = IDLE;
      last_d  = last_q;
      if (gnt0) begin
         last_d  = 1'b0;
         state_d = lock0 ? LOCK0 : IDLE;
      end else if (gnt1) begin
         last_d  = 1'b1;
         state_d = lock1 ? LOCK1 : IDLE;
      end
   end

   // A lock whose owner stops requesting falls through to the idle tie-break
   always_comb begin
      gnt0     = 1'b0;
      gnt1     = 1'b0;
      override = 1'b0;
      if (!rst) begin
         if (state_q == LOCK0 && req0) begin
            override = req1 && at_max;
            gnt1     = override;
            gnt0     = !override;
         end else if (state_q == LOCK1 && req1) begin
            override = req0 && at_max;
            gnt0     = override;
            gnt1     = !override;
         end else if (req0 && req1) begin
            gnt0 = last_q;
            gnt1 = !last_q;
         end else begin
            gnt0 = req0;
            gnt1 = req1;
         end
      end
   end

   always_comb begin
      denied   = (req0 && !gnt0) || (req1 && !gnt1);
      switched = (gnt0 || gnt1) && (gnt1 != last_q);
      mem_re   = (gnt0 && !we0) || (gnt1 && !we1);
      mem_we   = (gnt0 && we0) || (gnt1 && we1);
      memaddr  = '0;
      wmemdata = '0;
      if (gnt0) begin
         memaddr  = addr0;
         wmemdata = wdata0;
      end else if (gnt1) begin
         memaddr  = addr1;
         wmemdata = wdata1;
      end
      rd_valid_d = mem_re;
      rd_port_d  = gnt1;
   end

   assign rvalid0 = rd_valid_q && !rd_port_q;
   assign rvalid1 = rd_valid_q && rd_port_q;
   assign rdata   = rmemdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req1, we0, we1, lock0, lock1;
   logic [14:0] addr0, addr1, memaddr;
   logic [15:0] wdata0, wdata1, rdata, wmemdata;
   logic [15:0] rmemdata = 16'h0000;
   logic        gnt0, gnt1, rvalid0, rvalid1, mem_re, mem_we;
   int          checks = 0;
   int          errors = 0;

   mem_arbiter #(.AWIDTH(16), .DWIDTH(16), .MAXWAIT(3)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .lock0(lock0), .lock1(lock1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata(rdata), .mem_re(mem_re), .mem_we(mem_we),
      .memaddr(memaddr), .wmemdata(wmemdata), .rmemdata(rmemdata)
   );

   always #5 clk = ~clk;

   // memory returns the inverted word address one cycle after a read strobe
   always @(posedge clk) if (mem_re) rmemdata <= ~{1'b0, memaddr};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
      lock0 = 1'b0; lock1 = 1'b0; addr0 = 15'h0010; addr1 = 15'h0020;
      wdata0 = 16'h0000; wdata1 = 16'h0000;

      cyc(); #1;
      chk("rst_gnt0", 32'(gnt0), 32'd0);
      chk("rst_gnt1", 32'(gnt1), 32'd0);
      chk("rst_re", 32'(mem_re), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_rvalid", 32'({rvalid0, rvalid1}), 32'd0);

      cyc(); rst = 1'b0; #1;
      chk("rel_gnt0", 32'({gnt0, gnt1}), 32'b10);
      chk("tie0_addr", 32'(memaddr), 32'h0010);
      chk("tie0_re", 32'(mem_re), 32'd1);
      cyc(); #1;
      chk("tie1_gnt", 32'({gnt0, gnt1}), 32'b01);
      chk("tie1_addr", 32'(memaddr), 32'h0020);
      chk("tie1_rv", 32'({rvalid0, rvalid1}), 32'b10);
      chk("tie1_rdata", 32'(rdata), 32'hFFEF);
      cyc(); #1;
      chk("tie2_addr", 32'(memaddr), 32'h0010);
      chk("tie2_rv", 32'({rvalid0, rvalid1}), 32'b01);
      chk("tie2_rdata", 32'(rdata), 32'hFFDF);
      cyc(); #1;
      chk("tie3_addr", 32'(memaddr), 32'h0020);
      chk("tie3_rv", 32'({rvalid0, rvalid1}), 32'b10);
      chk("tie3_rdata", 32'(rdata), 32'hFFEF);
      cyc(); req0 = 1'b0; req1 = 1'b0; #1;
      chk("idle_gnt", 32'({gnt0, gnt1}), 32'b00);
      chk("idle_addr", 32'(memaddr), 32'h0000);
      chk("tie4_rv", 32'({rvalid0, rvalid1}), 32'b01);
      chk("tie4_rdata", 32'(rdata), 32'hFFDF);

      cyc(); req1 = 1'b1; we1 = 1'b1; addr1 = 15'h7FFF; wdata1 = 16'hBEEF; #1;
      chk("wr_gnt", 32'({gnt0, gnt1}), 32'b01);
      chk("wr_strobes", 32'({mem_re, mem_we}), 32'b01);
      chk("wr_addr", 32'(memaddr), 32'h7FFF);
      chk("wr_data", 32'(wmemdata), 32'hBEEF);
      cyc(); req1 = 1'b0; we1 = 1'b0; #1;
      chk("wr_norv", 32'({rvalid0, rvalid1}), 32'b00);
      chk("wr_done", 32'(mem_we), 32'd0);

      cyc(); req0 = 1'b1; lock0 = 1'b1; addr0 = 15'h0100; req1 = 1'b1; addr1 = 15'h0200; #1;
      chk("lk_c0", 32'({gnt0, gnt1}), 32'b10);
      cyc(); #1;
      chk("lk_c1", 32'({gnt0, gnt1}), 32'b10);
      cyc(); #1;
      chk("lk_c2", 32'({gnt0, gnt1}), 32'b10);
      cyc(); #1;
      chk("lk_c3_override", 32'({gnt0, gnt1}), 32'b01);
      chk("lk_c3_addr", 32'(memaddr), 32'h0200);
      cyc(); #1;
      chk("lk_c4_resume", 32'({gnt0, gnt1}), 32'b10);
      chk("lk_c4_rv", 32'({rvalid0, rvalid1}), 32'b01);
      chk("lk_c4_rdata", 32'(rdata), 32'hFDFF);
      cyc(); lock0 = 1'b0; #1;
      chk("rel_c5", 32'({gnt0, gnt1}), 32'b10);
      cyc(); #1;
      chk("rel_c6", 32'({gnt0, gnt1}), 32'b01);
      cyc(); req0 = 1'b0; req1 = 1'b0; #1;

      cyc(); req1 = 1'b1; lock1 = 1'b1; addr1 = 15'h0030; #1;
      chk("mr_gnt", 32'({gnt0, gnt1}), 32'b01);
      @(posedge clk); #1;
      rst = 1'b1; req1 = 1'b0; lock1 = 1'b0; #1;
      chk("mr_rv_in_rst", 32'(rvalid1), 32'd0);
      #1 rst = 1'b0;
      cyc(); req0 = 1'b1; req1 = 1'b1; addr0 = 15'h0040; addr1 = 15'h0050; #1;
      chk("mr_rv_after", 32'({rvalid0, rvalid1}), 32'b00);
      chk("mr_idle_tie", 32'({gnt0, gnt1}), 32'b10);
      cyc(); req0 = 1'b0; req1 = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
